// File: rtl/tcdm_varlat_xbar_if.sv
// Bundle of N TCDM ports (request, grant, in-order response) used on both the
// core side and the bank side of tcdm_varlat_xbar.
interface tcdm_varlat_xbar_if #(
    parameter int unsigned N  = 4,
    parameter int unsigned AW = 2,
    parameter int unsigned WW = 32,
    parameter int unsigned RW = 32
);
    logic [N-1:0]         req;
    logic [N-1:0][AW-1:0] add;
    logic [N-1:0]         wen;
    logic [N-1:0][WW-1:0] wdata;
    logic [N-1:0]         gnt;
    logic [N-1:0]         vld;
    logic [N-1:0][RW-1:0] rdata;

    modport master (
        output req, add, wen, wdata,
        input  gnt, vld, rdata
    );

    modport slave (
        input  req, add, wen, wdata,
        output gnt, vld, rdata
    );
endinterface

// File: rtl/tcdm_varlat_xbar.sv
// NumIn x NumOut crossbar for variable-latency TCDM banks with per-bank RR arbiter and ID FIFO.
// Define TCDM_VARLAT_XBAR_ASSERT_EN to compile simulation-only protocol checks.
module tcdm_varlat_xbar #(
    parameter int unsigned NumIn         = 4,
    parameter int unsigned NumOut        = 4,
    parameter int unsigned ReqDataWidth  = 32,
    parameter int unsigned RespDataWidth = 32,
    parameter int unsigned ExtPrio       = 0,
    localparam int unsigned IW = (NumIn  > 1) ? $clog2(NumIn)  : 1,
    localparam int unsigned AW = (NumOut > 1) ? $clog2(NumOut) : 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NumOut-1:0][IW-1:0]    rr_i,
    tcdm_varlat_xbar_if.slave            core,
    tcdm_varlat_xbar_if.master           bank
);

    localparam int unsigned CW = $clog2(NumIn + 1);

    logic [NumOut-1:0][IW-1:0]            ptr_q;
    logic [NumOut-1:0][NumIn-1:0][IW-1:0] fifo_q;
    logic [NumOut-1:0][IW-1:0]            wr_q;
    logic [NumOut-1:0][IW-1:0]            rd_q;
    logic [NumOut-1:0][CW-1:0]            cnt_q;
    logic [NumIn-1:0]                     busy_q;

    logic [NumIn-1:0]                     elig;
    logic [NumOut-1:0][IW-1:0]            win;
    logic [NumOut-1:0]                    hs;
    logic [NumOut-1:0]                    pop;

    function automatic logic [IW-1:0] inc_wrap(input logic [IW-1:0] v);
        return (v == IW'(NumIn - 1)) ? '0 : v + 1'b1;
    endfunction

    // Response routing: each bank's FIFO head names the master that owns the response.
    always_comb begin
        logic [IW-1:0] h;
        h          = '0;
        pop        = '0;
        core.vld   = '0;
        core.rdata = '0;
        for (int k = 0; k < NumOut; k++) begin
            pop[k] = bank.vld[k] && (cnt_q[k] != '0);
            if (pop[k]) begin
                h              = fifo_q[k][rd_q[k]];
                core.vld[h]    = 1'b1;
                core.rdata[h]  = bank.rdata[k];
            end
        end
    end

    // A busy master may issue again in the very cycle its response returns.
    always_comb begin
        for (int j = 0; j < NumIn; j++) begin
            elig[j] = core.req[j] && (!busy_q[j] || core.vld[j]);
        end
    end

    always_comb begin
        int unsigned start;
        int unsigned idx;
        logic        found;
        start      = 0;
        idx        = 0;
        found      = 1'b0;
        win        = '0;
        hs         = '0;
        bank.req   = '0;
        bank.add   = '0;
        bank.wen   = '0;
        bank.wdata = '0;
        core.gnt   = '0;
        for (int k = 0; k < NumOut; k++) begin
            found = 1'b0;
            start = (ExtPrio != 0) ? (32'(rr_i[k]) % NumIn) : 32'(ptr_q[k]);
            for (int unsigned off = 0; off < NumIn; off++) begin
                idx = (start + off) % NumIn;
                if (!found && elig[idx] && (core.add[idx] == AW'(k))) begin
                    found  = 1'b1;
                    win[k] = IW'(idx);
                end
            end
            if (found) begin
                bank.req[k]        = 1'b1;
                bank.wen[k]        = core.wen[win[k]];
                bank.wdata[k]      = core.wdata[win[k]];
                core.gnt[win[k]]   = bank.gnt[k];
                hs[k]              = bank.gnt[k];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q  <= '0;
            fifo_q <= '0;
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            busy_q <= '0;
        end else begin
            for (int k = 0; k < NumOut; k++) begin
                if (hs[k]) begin
                    fifo_q[k][wr_q[k]] <= win[k];
                    wr_q[k]            <= inc_wrap(wr_q[k]);
                    if (ExtPrio == 0) begin
                        ptr_q[k] <= inc_wrap(win[k]);
                    end
                end
                if (pop[k]) begin
                    rd_q[k] <= inc_wrap(rd_q[k]);
                end
                cnt_q[k] <= cnt_q[k] + CW'(hs[k]) - CW'(pop[k]);
            end
            // A same-cycle regrant outranks the clear from the returning response.
            for (int j = 0; j < NumIn; j++) begin
                if (core.gnt[j]) begin
                    busy_q[j] <= 1'b1;
                end else if (core.vld[j]) begin
                    busy_q[j] <= 1'b0;
                end
            end
        end
    end

`ifdef TCDM_VARLAT_XBAR_ASSERT_EN
    logic [NumIn-1:0]         pend_q;
    logic [NumIn-1:0][AW-1:0] add_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_q <= '0;
            add_q  <= '0;
        end else begin
            pend_q <= elig & ~core.gnt;
            add_q  <= core.add;
        end
    end

    always @(posedge clk_i) begin
        if (!rst_i) begin
            for (int k = 0; k < NumOut; k++) begin
                if (bank.vld[k] && (cnt_q[k] == '0)) begin
                    $error("tcdm_varlat_xbar: response on bank %0d with no outstanding request", k);
                end
            end
            for (int j = 0; j < NumIn; j++) begin
                if (core.gnt[j] && (32'(core.add[j]) >= NumOut)) begin
                    $error("tcdm_varlat_xbar: master %0d granted out-of-range bank", j);
                end
                if (pend_q[j] && (!core.req[j] || (core.add[j] != add_q[j]))) begin
                    $error("tcdm_varlat_xbar: master %0d dropped or changed request before grant", j);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_tcdm_varlat_xbar.sv
// Scoreboard bench for tcdm_varlat_xbar: arbitration order, stalls, in-order response routing, reset.
module tb_tcdm_varlat_xbar;
    localparam int NI = 4;
    localparam int NO = 4;
    localparam int IW = 2;
    localparam int AW = 2;
    localparam int WW = 32;
    localparam int RW = 32;

    typedef struct {
        int          m;
        logic [31:0] d;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NO-1:0][IW-1:0] rr = '0;

    exp_t sbq[$];
    int   n_vec = 0;
    int   n_err = 0;

    tcdm_varlat_xbar_if #(.N(NI), .AW(AW), .WW(WW), .RW(RW)) core ();
    tcdm_varlat_xbar_if #(.N(NO), .AW(AW), .WW(WW), .RW(RW)) bank ();

    tcdm_varlat_xbar #(
        .NumIn(NI), .NumOut(NO), .ReqDataWidth(WW), .RespDataWidth(RW), .ExtPrio(0)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .rr_i  (rr),
        .core  (core),
        .bank  (bank)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cyc();
        @(negedge clk);
        bank.vld   = '0;
        bank.rdata = '0;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic push_resp(input int k, input int m, input logic [31:0] d);
        exp_t e;
        bank.vld[k]   = 1'b1;
        bank.rdata[k] = d;
        e.m = m;
        e.d = d;
        sbq.push_back(e);
    endtask

    task automatic check_resp();
        logic [NI-1:0] mask;
        exp_t          e;
        mask = '0;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            mask[e.m] = 1'b1;
            chk("resp_data", core.rdata[e.m], e.d);
        end
        chk("resp_vld", core.vld, mask);
        for (int j = 0; j < NI; j++) begin
            if (!mask[j]) chk("rdata_idle", core.rdata[j], 0);
        end
    endtask

    initial begin
        core.req   = '0;
        core.add   = '0;
        core.wen   = '0;
        core.wdata = '0;
        bank.gnt   = '0;
        bank.vld   = '0;
        bank.rdata = '0;

        settle();
        chk("rst_gnt", core.gnt, 0);
        chk("rst_req", bank.req, 0);
        chk("rst_vld", core.vld, 0);

        next_cyc();
        rst = 1'b0;
        settle();
        chk("idle_gnt", core.gnt, 0);
        chk("idle_req", bank.req, 0);
        chk("idle_wdata", bank.wdata, 0);
        check_resp();

        // master 0 loads bank 2, response three cycles after the grant
        next_cyc();
        core.req[0]   = 1'b1;
        core.add[0]   = 2'd2;
        core.wen[0]   = 1'b0;
        core.wdata[0] = 32'hDEAD;
        bank.gnt[2]   = 1'b1;
        settle();
        chk("t1_req", bank.req, 4'b0100);
        chk("t1_gnt", core.gnt, 4'b0001);
        chk("t1_wen", bank.wen, 0);
        next_cyc();
        core.req = '0;
        bank.gnt = '0;
        settle();
        check_resp();
        next_cyc();
        settle();
        check_resp();
        next_cyc();
        push_resp(2, 0, 32'hA5);
        settle();
        check_resp();

        // four masters contend for bank 1
        next_cyc();
        core.req    = '1;
        core.add    = {4{2'd1}};
        bank.gnt[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) next_cyc();
            settle();
            chk("rr_gnt", core.gnt, 64'(1) << i);
        end
        for (int i = 0; i < 4; i++) begin
            next_cyc();
            if (i == 0) begin
                core.req = '0;
                bank.gnt = '0;
            end
            push_resp(1, i, 32'h100 + 32'(i));
            settle();
            check_resp();
        end

        // distinct banks all granted together
        next_cyc();
        core.req = '1;
        for (int j = 0; j < NI; j++) core.add[j] = AW'(j);
        bank.gnt = '1;
        settle();
        chk("par_gnt", core.gnt, 4'hF);
        chk("par_req", bank.req, 4'hF);
        next_cyc();
        core.req = '0;
        bank.gnt = '0;
        for (int k = 0; k < NO; k++) push_resp(k, k, 32'h200 + 32'(k));
        settle();
        check_resp();

        // bank 0 stalls; its pointer sits at 1 so master 2 wins and must stay presented
        next_cyc();
        core.req      = 4'b0101;
        core.add[0]   = 2'd0;
        core.add[2]   = 2'd0;
        core.wen[0]   = 1'b1;
        core.wen[2]   = 1'b1;
        core.wdata[0] = 32'hAAAA0000;
        core.wdata[2] = 32'hCCCC2222;
        bank.gnt      = '0;
        for (int c = 0; c < 2; c++) begin
            if (c > 0) next_cyc();
            settle();
            chk("stall_gnt", core.gnt, 0);
            chk("stall_req", bank.req[0], 1);
            chk("stall_wdata", bank.wdata[0], 32'hCCCC2222);
            chk("stall_wen", bank.wen[0], 1);
        end
        next_cyc();
        bank.gnt[0] = 1'b1;
        settle();
        chk("stall_release", core.gnt, 4'b0100);
        next_cyc();
        core.req[2] = 1'b0;
        settle();
        chk("stall_next", core.gnt, 4'b0001);
        chk("stall_next_wdata", bank.wdata[0], 32'hAAAA0000);
        next_cyc();
        core.req = '0;
        core.wen = '0;
        bank.gnt = '0;
        push_resp(0, 2, 32'h5);
        settle();
        check_resp();
        next_cyc();
        push_resp(0, 0, 32'h6);
        settle();
        check_resp();

        // masters 2 then 0 to bank 3; responses come back in grant order
        next_cyc();
        core.req    = 4'b0100;
        core.add[2] = 2'd3;
        bank.gnt[3] = 1'b1;
        settle();
        chk("ord_g2", core.gnt, 4'b0100);
        next_cyc();
        core.req    = 4'b0001;
        core.add[0] = 2'd3;
        settle();
        chk("ord_g0", core.gnt, 4'b0001);
        next_cyc();
        core.req = '0;
        bank.gnt = '0;
        settle();
        check_resp();
        next_cyc();
        push_resp(3, 2, 32'h11);
        settle();
        check_resp();
        next_cyc();
        settle();
        check_resp();
        next_cyc();
        push_resp(3, 0, 32'h22);
        settle();
        check_resp();

        // back-to-back: busy master regranted in its response cycle
        next_cyc();
        core.req    = 4'b0010;
        core.add[1] = 2'd2;
        bank.gnt[2] = 1'b1;
        settle();
        chk("b2b_first", core.gnt, 4'b0010);
        next_cyc();
        settle();
        chk("b2b_busy", core.gnt, 0);
        check_resp();
        next_cyc();
        push_resp(2, 1, 32'h33);
        settle();
        chk("b2b_regrant", core.gnt, 4'b0010);
        check_resp();
        next_cyc();
        core.req = '0;
        bank.gnt = '0;
        settle();
        check_resp();
        next_cyc();
        push_resp(2, 1, 32'h44);
        settle();
        check_resp();

        // reset with two transactions outstanding
        next_cyc();
        core.req    = 4'b1001;
        core.add[0] = 2'd0;
        core.add[3] = 2'd3;
        bank.gnt    = '1;
        settle();
        chk("pre_rst_gnt", core.gnt, 4'b1001);
        next_cyc();
        core.req = '0;
        bank.gnt = '0;
        #2;
        rst = 1'b1;
        bank.vld[0]   = 1'b1;
        bank.rdata[0] = 32'h77;
        #1;
        chk("in_rst_vld", core.vld, 0);
        next_cyc();
        rst = 1'b0;
        bank.vld      = 4'b1001;
        bank.rdata[0] = 32'h77;
        bank.rdata[3] = 32'h88;
        settle();
        check_resp();

        // busy flags and pointers cleared: master 0 free again, bank 1 restarts at master 1
        next_cyc();
        core.req    = 4'b0111;
        core.add[0] = 2'd0;
        core.add[1] = 2'd1;
        core.add[2] = 2'd1;
        bank.gnt    = 4'b0011;
        settle();
        chk("post_rst_gnt", core.gnt, 4'b0011);
        next_cyc();
        core.req = '0;
        bank.gnt = '0;
        settle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/tcdm_varlat_xbar.md
# tcdm_varlat_xbar

Full NumIn×NumOut crossbar for variable-latency TCDM banks. It sits between cluster cores (masters) and memory banks (slaves). Each master has a bank-index decoder and a response mux. Each bank has a round-robin arbiter and an in-order ID FIFO, so responses that arrive after any number of cycles are routed back to the master that issued the request.

## Interface
- NumIn, 4: number of masters (≥1)
- NumOut, 4: number of banks (≥1)
- ReqDataWidth, 32: write-data width
- RespDataWidth, 32: read-data width
- ExtPrio, 0: 1 = arbiter priority from rr_i; 0 = internal RR pointer
- IW = max(1,$clog2(NumIn)); AW = max(1,$clog2(NumOut))
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- rr_i  in  NumOut×IW  external priority index per bank (used only if ExtPrio)
- req_i  in  NumIn  master request
- add_i  in  NumIn×AW  target bank index
- wen_i  in  NumIn  1 store, 0 load
- wdata_i  in  NumIn×ReqDataWidth  write data
- gnt_o  out  NumIn  grant, combinational
- vld_o  out  NumIn  response valid (loads and stores)
- rdata_o  out  NumIn×RespDataWidth  response data
- req_o  out  NumOut  bank request
- wen_o  out  NumOut  forwarded wen of the winner
- wdata_o  out  NumOut×ReqDataWidth  forwarded write data of the winner
- gnt_i  in  NumOut  bank grant
- vld_i  in  NumOut  bank response valid, one per accepted request, in order
- rdata_i  in  NumOut×RespDataWidth  bank response data

## Operation
- Decode: master j eligible for bank add_i[j] when req_i[j] && !busy_j, or when req_i[j] && busy_j && vld_o[j] this cycle (back-to-back).
  - add_i ≥ NumOut: never eligible, never granted.
- Arbitration per bank k:
  - Round-robin over eligible masters, starting at pointer p_k (rr_i[k] if ExtPrio).
  - Winner w drives req_o[k]=1 and wen_o[k]/wdata_o[k]=its signals.
  - With no eligible master: req_o[k]=0 and wen_o/wdata_o=0.
- Grant: gnt_o[w] = gnt_i[k]. All others 0. Handshake = req_o[k]&&gnt_i[k].
- Pointer update (internal mode): on handshake p_k ← (w+1) mod NumIn. Otherwise it holds, and the request stays presented with no reshuffle.
- ID FIFO per bank, depth NumIn:
  - Push w on handshake.
  - On vld_i[k], pop head h; drive vld_o[h]=1 and rdata_o[h]=rdata_i[k].
  - Simultaneous push/pop allowed, including when full.
- busy_j set on grant, cleared on the response. One outstanding transaction per master.
- rdata_o[j]=0 when vld_o[j]=0.
- vld_i[k] with an empty FIFO is ignored.

## Timing
- gnt_o, req_o, wen_o and wdata_o are combinational from req_i/add_i/gnt_i, with zero added latency.
- Response latency equals bank latency: vld_o is combinational from vld_i with 0 cycles added. Earliest is the cycle after the grant.
- State: p_k, FIFOs and busy flags only.
- On rst_i (asynchronous, any time):
  - p_k=0, FIFOs empty, busy=0.
  - Outstanding transactions are abandoned; late vld_i is ignored.
  - Outputs become 0 whenever req_i=0.
- Collisions: several masters to one bank → one grant per cycle. Masters to distinct banks → all granted the same cycle.

## Configuration
- TCDM_VARLAT_XBAR_ASSERT_EN defined: simulation-only checks that raise $error on:
  - vld_i[k] with an empty FIFO
  - granted add_i ≥ NumOut
  - req_i dropped or add_i changed before grant
- Undefined: no checks compiled. Functional behaviour is identical either way.

## Test plan
- Reset, then idle: all outputs 0. Master 0 loads bank 2, gnt_i=1, and the bank responds 3 cycles later with rdata=0xA5 → vld_o[0]=1, rdata_o[0]=0xA5 on that same cycle.
- Masters 0–3 hold requests to bank 1 with gnt_i=1 for 4 cycles → grants go to 0,1,2,3 in order, one per cycle.
- Masters 0–3 each target a different bank → all four gnt_o=1 in one cycle.
- Bank 0 gnt_i=0 for 2 cycles → gnt_o=0 and req_o stays asserted with the same wdata; the pointer holds. Raising gnt_i grants the same master.
- Masters 2 and 0 are granted to bank 3 in that order. Responses 0x11 and 0x22 → 0x11 goes to master 2, then 0x22 to master 0.
- Master busy, new request in the cycle its response arrives → granted that cycle. Assert rst_i with 2 outstanding → FIFOs clear and no vld_o follows.
